// File: rtl/lcd_dbi_pkg.sv
// lcd_dbi_pkg: DCS command codes and classifier state encoding for the DBI type B receiver.
package lcd_dbi_pkg;
    localparam logic [7:0] SWRESET = 8'h01;
    localparam logic [7:0] CASET   = 8'h2A;
    localparam logic [7:0] PASET   = 8'h2B;
    localparam logic [7:0] RAMWR   = 8'h2C;
    localparam logic [7:0] RAMWRC  = 8'h3C;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] PARAM  = 2'd1;
    localparam logic [1:0] PIX_HI = 2'd2;
    localparam logic [1:0] PIX_LO = 2'd3;
endpackage

// File: rtl/lcd_dbi_receiver_if.sv
// lcd_dbi_receiver_if: 8080 bus pins from the host plus the latch strobes toward framebuffer_writer.
interface lcd_dbi_receiver_if;
    logic        lcd_cs_n;
    logic        lcd_wr_n;
    logic        lcd_rs;
    logic [7:0]  lcd_d;
    logic [7:0]  command;
    logic        command_latch;
    logic [7:0]  param;
    logic        param_latch;
    logic [15:0] rgb565;
    logic        rgb565_latch;
    logic        pixel_drop;

    modport slave (
        input  lcd_cs_n, lcd_wr_n, lcd_rs, lcd_d,
        output command, command_latch, param, param_latch, rgb565, rgb565_latch, pixel_drop
    );
    modport master (
        output lcd_cs_n, lcd_wr_n, lcd_rs, lcd_d,
        input  command, command_latch, param, param_latch, rgb565, rgb565_latch, pixel_drop
    );
endinterface

// File: rtl/lcd_bus_sync.sv
// lcd_bus_sync: synchronises the 11 bus pins and emits registered byte and CS-release events.
module lcd_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       rs,
    input  logic [7:0] d,
    output logic       byte_valid,
    output logic       byte_rs,
    output logic [7:0] byte_data,
    output logic       cs_release
);
    // cs_n and wr_n reset high so an idle bus produces no edge when reset is released
    localparam logic [10:0] RST_V = 11'h600;
    logic [SYNC_STAGES-1:0][10:0] sync;
    logic [10:0] last;
    logic wr_prev, cs_prev;
    assign last = sync[SYNC_STAGES-1];
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync       <= {SYNC_STAGES{RST_V}};
            wr_prev    <= 1'b1;
            cs_prev    <= 1'b1;
            byte_valid <= 1'b0;
            byte_rs    <= 1'b0;
            byte_data  <= 8'h00;
            cs_release <= 1'b0;
        end else begin
            sync       <= {sync[SYNC_STAGES-2:0], {cs_n, wr_n, rs, d}};
            wr_prev    <= last[9];
            cs_prev    <= last[10];
            byte_valid <= !wr_prev && last[9] && !last[10];
            byte_rs    <= last[8];
            byte_data  <= last[7:0];
            cs_release <= !cs_prev && last[10];
        end
    end
endmodule

// File: rtl/lcd_dbi_receiver.sv
// lcd_dbi_receiver: classifies synchronised bus bytes into commands, parameters and RGB565 pixels.
module lcd_dbi_receiver
    import lcd_dbi_pkg::*;
#(
    parameter int         SYNC_STAGES    = 2,
    parameter logic [7:0] PIXEL_CMD      = RAMWR,
    parameter logic [7:0] PIXEL_CONT_CMD = RAMWRC
) (
    input logic               i_clk,
    input logic               i_rst_n,
    lcd_dbi_receiver_if.slave bus
);
    logic       byte_valid, byte_rs, cs_release;
    logic [7:0] byte_data;
    logic [1:0] state;
    logic [7:0] hi, command, param;
    logic [15:0] rgb565;
    logic command_latch, param_latch, rgb565_latch, pixel_drop;

    lcd_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .cs_n       (bus.lcd_cs_n),
        .wr_n       (bus.lcd_wr_n),
        .rs         (bus.lcd_rs),
        .d          (bus.lcd_d),
        .byte_valid (byte_valid),
        .byte_rs    (byte_rs),
        .byte_data  (byte_data),
        .cs_release (cs_release)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            hi            <= 8'h00;
            command       <= 8'h00;
            param         <= 8'h00;
            rgb565        <= 16'h0000;
            command_latch <= 1'b0;
            param_latch   <= 1'b0;
            rgb565_latch  <= 1'b0;
            pixel_drop    <= 1'b0;
        end else begin
            command_latch <= 1'b0;
            param_latch   <= 1'b0;
            rgb565_latch  <= 1'b0;
            pixel_drop    <= 1'b0;
            if (byte_valid && !byte_rs) begin
                command       <= byte_data;
                command_latch <= 1'b1;
                pixel_drop    <= state == PIX_LO;
                state         <= (byte_data == PIXEL_CMD || byte_data == PIXEL_CONT_CMD) ? PIX_HI : PARAM;
            end else if (byte_valid && state == PARAM) begin
                param       <= byte_data;
                param_latch <= 1'b1;
            end else if (byte_valid && state == PIX_HI) begin
                hi    <= byte_data;
                state <= PIX_LO;
            end else if (byte_valid && state == PIX_LO) begin
                rgb565       <= {hi, byte_data};
                rgb565_latch <= 1'b1;
                state        <= PIX_HI;
            end else if (cs_release && state == PIX_LO) begin
                // half pixel is lost but the stream mode survives the CS gap
                pixel_drop <= 1'b1;
                state      <= PIX_HI;
            end
        end
    end

    assign bus.command       = command;
    assign bus.command_latch = command_latch;
    assign bus.param         = param;
    assign bus.param_latch   = param_latch;
    assign bus.rgb565        = rgb565;
    assign bus.rgb565_latch  = rgb565_latch;
    assign bus.pixel_drop    = pixel_drop;
endmodule

// File: tb/tb_lcd_dbi_receiver.sv
// tb_lcd_dbi_receiver: scoreboard bench driving directed 8080 bus transactions.
module tb_lcd_dbi_receiver;
    localparam int SYNC = 2;
    localparam int K_NONE = 0, K_CMD = 1, K_PAR = 2, K_PIX = 3, K_DROP = 4;

    typedef struct {
        int          kind;
        logic [15:0] val;
        int          cyc;
    } exp_t;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    int cyc = 0;
    int total = 0;
    int bad = 0;
    exp_t exp_q[$];

    lcd_dbi_receiver_if bus ();

    lcd_dbi_receiver #(.SYNC_STAGES(SYNC)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    // strobe appears SYNC+1 edges after the first edge that samples the pin change
    task automatic push(input int kind, input logic [15:0] val);
        exp_t e;
        if (kind == K_NONE) return;
        e.kind = kind;
        e.val  = val;
        e.cyc  = cyc + SYNC + 2;
        exp_q.push_back(e);
    endtask

    task automatic wr(input logic rs, input logic [7:0] d, input int k0, input logic [15:0] v0,
                      input int k1 = K_NONE, input logic [15:0] v1 = 16'h0);
        @(negedge i_clk);
        bus.lcd_rs   = rs;
        bus.lcd_d    = d;
        bus.lcd_wr_n = 1'b0;
        repeat (3) @(negedge i_clk);
        bus.lcd_wr_n = 1'b1;
        push(k0, v0);
        push(k1, v1);
        repeat (3) @(negedge i_clk);
    endtask

    task automatic check(input string name, input int kind, input logic [15:0] val);
        exp_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: unexpected strobe val=%h at cyc=%0d", name, val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val || e.cyc != cyc) begin
                bad++;
                $display("FAIL %s: got kind=%0d val=%h cyc=%0d, want kind=%0d val=%h cyc=%0d",
                         name, kind, val, cyc, e.kind, e.val, e.cyc);
            end
        end
    endtask

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    always @(negedge i_clk) begin
        if (bus.command_latch) check("command", K_CMD, {8'h00, bus.command});
        if (bus.pixel_drop)    check("pixel_drop", K_DROP, 16'h0000);
        if (bus.param_latch)   check("param", K_PAR, {8'h00, bus.param});
        if (bus.rgb565_latch)  check("rgb565", K_PIX, bus.rgb565);
    end

    task automatic check_zero(input string tag);
        cmp({tag, " command"}, {8'h00, bus.command}, 16'h0);
        cmp({tag, " param"}, {8'h00, bus.param}, 16'h0);
        cmp({tag, " rgb565"}, bus.rgb565, 16'h0);
        cmp({tag, " strobes"}, {12'h0, bus.command_latch, bus.param_latch, bus.rgb565_latch, bus.pixel_drop}, 16'h0);
    endtask

    initial begin
        bus.lcd_cs_n = 1'b1;
        bus.lcd_wr_n = 1'b1;
        bus.lcd_rs   = 1'b0;
        bus.lcd_d    = 8'h00;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (100) @(negedge i_clk);
        check_zero("idle");
        bus.lcd_cs_n = 1'b0;
        repeat (3) @(negedge i_clk);

        wr(1'b0, 8'h2A, K_CMD, 16'h002A);
        wr(1'b1, 8'h00, K_PAR, 16'h0000);
        wr(1'b1, 8'h10, K_PAR, 16'h0010);
        wr(1'b1, 8'h01, K_PAR, 16'h0001);
        wr(1'b1, 8'h3F, K_PAR, 16'h003F);

        wr(1'b0, 8'h2C, K_CMD, 16'h002C);
        wr(1'b1, 8'hF8, K_NONE, 16'h0);
        wr(1'b1, 8'h00, K_PIX, 16'hF800);
        wr(1'b1, 8'h07, K_NONE, 16'h0);
        wr(1'b1, 8'hE0, K_PIX, 16'h07E0);
        cmp("param hold", {8'h00, bus.param}, 16'h003F);

        wr(1'b0, 8'h2C, K_CMD, 16'h002C);
        wr(1'b1, 8'hAB, K_NONE, 16'h0);
        wr(1'b0, 8'h3C, K_CMD, 16'h003C, K_DROP, 16'h0);
        wr(1'b1, 8'h12, K_NONE, 16'h0);
        wr(1'b1, 8'h34, K_PIX, 16'h1234);

        wr(1'b0, 8'h2C, K_CMD, 16'h002C);
        wr(1'b1, 8'h55, K_NONE, 16'h0);
        @(negedge i_clk);
        bus.lcd_cs_n = 1'b1;
        push(K_DROP, 16'h0);
        repeat (2) @(negedge i_clk);
        bus.lcd_d = 8'h99;
        bus.lcd_rs = 1'b1;
        bus.lcd_wr_n = 1'b0;
        repeat (3) @(negedge i_clk);
        bus.lcd_wr_n = 1'b1;
        repeat (5) @(negedge i_clk);
        bus.lcd_cs_n = 1'b0;
        repeat (2) @(negedge i_clk);
        wr(1'b1, 8'h00, K_NONE, 16'h0);
        wr(1'b1, 8'h1F, K_PIX, 16'h001F);

        wr(1'b0, 8'h2C, K_CMD, 16'h002C);
        wr(1'b1, 8'h12, K_NONE, 16'h0);
        repeat (4) @(negedge i_clk);
        i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        check_zero("reset");
        i_rst_n = 1'b1;
        repeat (5) @(negedge i_clk);
        wr(1'b1, 8'h34, K_NONE, 16'h0);
        wr(1'b0, 8'h2C, K_CMD, 16'h002C);
        wr(1'b1, 8'h12, K_NONE, 16'h0);
        wr(1'b1, 8'h34, K_PIX, 16'h1234);

        repeat (10) @(negedge i_clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending: %0d expected strobes never seen, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
